fb_line_fetcher: RTL and testbench

- Upstream pixel source for the 640x480 VGA timing stage; drives its 8-bit RRRGGGBB colour input.
- Reads a 160x120 RRRGGGBB framebuffer from external synchronous memory and upscales it 4x in both axes.
- Two ping-pong 160-entry line buffers: the next source row is prefetched while the current row is displayed, so colour is available combinationally from pixel_x/pixel_y.

---
 rtl/fb_line_fetcher_if.sv | 21 ++
 rtl/fb_line_fetcher.sv | 164 ++++++++++++++++
 tb/tb_fb_line_fetcher.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_line_fetcher_if.sv
// Framebuffer read port between the line fetcher and external
// synchronous memory.
interface fb_line_fetcher_if #(
   parameter int ADDR_W = 15
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rd_data
   );
endinterface

// File: rtl/fb_line_fetcher.sv
// 160x120 framebuffer to 640x480 pixel source: 4x upscale with
// ping-pong line buffers, next source row prefetched during display.
module fb_line_fetcher #(
   parameter int         SRC_W          = 160,
   parameter int         SRC_H          = 120,
   parameter int         ADDR_W         = 15,
   parameter int         READ_LATENCY   = 1,
   parameter logic [7:0] UNDERRUN_COLOR = 8'hE3
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              display_enable,
   input  logic              frame_sync,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic              clear_status,
   fb_line_fetcher_if.master mem,
   output logic [7:0]        color_out,
   output logic              underrun,
   output logic              fetch_overrun
);
   localparam int CW = $clog2(SRC_W);
   localparam int RW = $clog2(SRC_H);
   localparam int L  = READ_LATENCY;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state;
   logic              de_q;
   logic [ADDR_W-1:0] base;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic              tgt;
   logic [1:0]        buf_valid;
   logic [7:0]        lbuf [2][SRC_W];
   logic [L-1:0]      pv;
   logic [L-1:0]      pl;
   logic [CW-1:0]     pc [L];
   logic              show_bad;

   logic          line_end;
   logic [7:0]    yr;
   logic [1:0]    yl;
   logic          row_go;
   logic          row_drop;
   logic [RW-1:0] next_row;
   logic          wr_en;
   logic          wr_done;
   logic          unused_ok;

   assign line_end  = de_q & ~display_enable;
   assign yr        = pixel_y[9:2];
   assign yl        = pixel_y[1:0];
   assign row_go    = line_end && yl == 2'd0 && yr < 8'(SRC_H - 1);
   assign row_drop  = line_end && yl == 2'd3;
   assign next_row  = RW'(yr + 8'd1);
   assign wr_en     = pv[L-1];
   assign wr_done   = pv[L-1] & pl[L-1];
   assign unused_ok = ^pixel_x[1:0];

   function automatic logic [ADDR_W-1:0] row_addr(
      input logic [ADDR_W-1:0] b,
      input logic [RW-1:0]     r
   );
      return b + ADDR_W'(32'(r) * SRC_W);
   endfunction

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         mem.mem_rd_en <= 1'b0;
         mem.mem_addr  <= '0;
         base          <= '0;
         row           <= '0;
         col           <= '0;
         tgt           <= 1'b0;
      end else if (frame_sync) begin
         // frame_sync always wins: restart at row 0 with the new base
         state         <= ISSUE;
         mem.mem_rd_en <= 1'b1;
         mem.mem_addr  <= fb_base;
         base          <= fb_base;
         row           <= '0;
         col           <= '0;
         tgt           <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (row_go) begin
               state         <= ISSUE;
               mem.mem_rd_en <= 1'b1;
               mem.mem_addr  <= row_addr(base, next_row);
               row           <= next_row;
               col           <= '0;
               tgt           <= next_row[0];
            end
            ISSUE: if (col == CW'(SRC_W - 1)) begin
               state         <= DRAIN;
               mem.mem_rd_en <= 1'b0;
            end else begin
               col          <= col + CW'(1);
               mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
            end
            DRAIN: if (wr_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         pv <= '0;
         pl <= '0;
         for (int k = 0; k < L; k++) pc[k] <= '0;
      end else begin
         pv[0] <= state == ISSUE;
         pl[0] <= col == CW'(SRC_W - 1);
         pc[0] <= col;
         for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pl[k] <= pl[k-1];
            pc[k] <= pc[k-1];
         end
         if (frame_sync) pv <= '0;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (wr_en) lbuf[tgt][pc[L-1]] <= mem.mem_rd_data;
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         de_q          <= 1'b0;
         buf_valid     <= '0;
         underrun      <= 1'b0;
         fetch_overrun <= 1'b0;
      end else begin
         de_q <= display_enable;
         if (wr_done)    buf_valid[tgt]   <= 1'b1;
         if (row_drop)   buf_valid[yr[0]] <= 1'b0;
         if (frame_sync) buf_valid        <= '0;
         if (show_bad)          underrun <= 1'b1;
         else if (clear_status) underrun <= 1'b0;
         if (row_go && state != IDLE && !frame_sync)
            fetch_overrun <= 1'b1;
         else if (clear_status)
            fetch_overrun <= 1'b0;
      end
   end

   always_comb begin
      color_out = 8'h00;
      show_bad  = 1'b0;
      if (display_enable) begin
         if (buf_valid[pixel_y[2]]) begin
            color_out = lbuf[pixel_y[2]][pixel_x[9:2]];
         end else begin
            color_out = UNDERRUN_COLOR;
            show_bad  = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fb_line_fetcher.sv
// Scoreboard bench for fb_line_fetcher: two instances (read latency
// 1 and 3) against a fetch-event reference model.
module tb_fb_line_fetcher;
   localparam int AW = 15;

   logic          pixel_clk = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    pixel_x = '0;
   logic [9:0]    pixel_y = '0;
   logic          display_enable = 1'b0;
   logic          frame_sync = 1'b0;
   logic [AW-1:0] fb_base = '0;
   logic          clear_status = 1'b0;
   logic [7:0]    color_a, color_b;
   logic          ur_a, ur_b, ov_a, ov_b;

   fb_line_fetcher_if #(.ADDR_W(AW)) mem_a ();
   fb_line_fetcher_if #(.ADDR_W(AW)) mem_b ();

   fb_line_fetcher #(.READ_LATENCY(1)) dut_a (
      .pixel_clk(pixel_clk), .reset(reset),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .display_enable(display_enable), .frame_sync(frame_sync),
      .fb_base(fb_base), .clear_status(clear_status),
      .mem(mem_a), .color_out(color_a),
      .underrun(ur_a), .fetch_overrun(ov_a)
   );

   fb_line_fetcher #(.READ_LATENCY(3)) dut_b (
      .pixel_clk(pixel_clk), .reset(reset),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .display_enable(display_enable), .frame_sync(frame_sync),
      .fb_base(fb_base), .clear_status(clear_status),
      .mem(mem_b), .color_out(color_b),
      .underrun(ur_b), .fetch_overrun(ov_b)
   );

   always #20 pixel_clk = ~pixel_clk;

   function automatic logic [7:0] mem_word(input logic [14:0] a);
      return a[7:0] ^ {a[14:8], 1'b0};
   endfunction

   logic [7:0] p1, p2;
   always @(posedge pixel_clk) begin
      mem_a.mem_rd_data <= mem_word(mem_a.mem_addr);
      p1 <= mem_word(mem_b.mem_addr);
      p2 <= p1;
      mem_b.mem_rd_data <= p2;
   end

   typedef struct packed {
      logic          rd;
      logic [AW-1:0] addr;
      logic [7:0]    color;
      logic          ur;
      logic          ov;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   running = 0;

   // reference model: one pending fetch event per instance
   int lat[2] = '{1, 3};
   bit f_act[2];
   int f_s[2], f_base[2], f_row[2], f_tgt[2];
   bit bv[2][2];
   int c_base[2][2], c_row[2][2];
   int l_base[2];
   bit m_ur[2], m_ov[2];
   bit prev_de;
   int cyc = 0;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         f_act[i] = 0; l_base[i] = 0; m_ur[i] = 0; m_ov[i] = 0;
         bv[i][0] = 0; bv[i][1] = 0;
      end
      prev_de = 0;
   endtask

   task automatic start(input int i, input int e, input int b, input int r);
      f_act[i] = 1; f_s[i] = e; f_base[i] = b;
      f_row[i] = r; f_tgt[i] = r % 2;
   endtask

   task automatic tick();
      exp_t e;
      bit   bad[2];
      bit   busy, ovset, le;
      int   b, yr, yl, ed;
      if (reset) model_reset();
      for (int i = 0; i < 2; i++) begin
         e = '0;
         bad[i] = 0;
         if (f_act[i] && cyc >= f_s[i] && cyc < f_s[i] + 160) begin
            e.rd = 1'b1;
            e.addr = 15'(f_base[i] + f_row[i] * 160 + (cyc - f_s[i]));
         end
         if (display_enable) begin
            b = int'(pixel_y[2]);
            if (bv[i][b])
               e.color = mem_word(15'(c_base[i][b] + c_row[i][b] * 160
                                      + int'(pixel_x) / 4));
            else begin
               e.color = 8'hE3;
               bad[i] = 1;
            end
         end
         e.ur = m_ur[i];
         e.ov = m_ov[i];
         if (i == 0) q_a.push_back(e);
         else q_b.push_back(e);
      end
      if (!reset) begin
         ed = cyc + 1;
         le = prev_de && !display_enable;
         yr = int'(pixel_y) / 4;
         yl = int'(pixel_y) % 4;
         for (int i = 0; i < 2; i++) begin
            busy = f_act[i];
            ovset = 0;
            if (f_act[i] && ed == f_s[i] + 160 + lat[i]) begin
               bv[i][f_tgt[i]] = 1;
               c_base[i][f_tgt[i]] = f_base[i];
               c_row[i][f_tgt[i]] = f_row[i];
               f_act[i] = 0;
            end
            if (le && yl == 3) bv[i][yr % 2] = 0;
            if (frame_sync) begin
               bv[i][0] = 0; bv[i][1] = 0;
               l_base[i] = int'(fb_base);
               start(i, ed, int'(fb_base), 0);
            end else if (le && yl == 0 && yr < 119) begin
               if (busy) ovset = 1;
               else start(i, ed, l_base[i], yr + 1);
            end
            m_ur[i] = bad[i] ? 1'b1 : clear_status ? 1'b0 : m_ur[i];
            m_ov[i] = ovset ? 1'b1 : clear_status ? 1'b0 : m_ov[i];
         end
         prev_de = display_enable;
      end else begin
         prev_de = 0;
      end
      cyc++;
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic check_one(input int i, input logic rd,
                            input logic [AW-1:0] a, input logic [7:0] c,
                            input logic u, input logic o);
      exp_t e;
      vectors++;
      if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
         miscompares++;
         $display("FAIL lat%0d no_expectation at %0t", lat[i], $time);
         return;
      end
      if (i == 0) e = q_a.pop_front();
      else e = q_b.pop_front();
      if (rd !== e.rd) begin
         miscompares++;
         $display("FAIL lat%0d rd_en got %b want %b at %0t",
                  lat[i], rd, e.rd, $time);
      end else if (e.rd && a !== e.addr) begin
         miscompares++;
         $display("FAIL lat%0d mem_addr got %h want %h at %0t",
                  lat[i], a, e.addr, $time);
      end
      if (c !== e.color) begin
         miscompares++;
         $display("FAIL lat%0d color_out got %h want %h x=%0d y=%0d at %0t",
                  lat[i], c, e.color, pixel_x, pixel_y, $time);
      end
      if (u !== e.ur) begin
         miscompares++;
         $display("FAIL lat%0d underrun got %b want %b at %0t",
                  lat[i], u, e.ur, $time);
      end
      if (o !== e.ov) begin
         miscompares++;
         $display("FAIL lat%0d fetch_overrun got %b want %b at %0t",
                  lat[i], o, e.ov, $time);
      end
   endtask

   always @(negedge pixel_clk) begin
      if (running) begin
         check_one(0, mem_a.mem_rd_en, mem_a.mem_addr, color_a, ur_a, ov_a);
         check_one(1, mem_b.mem_rd_en, mem_b.mem_addr, color_b, ur_b, ov_b);
      end
   end

   task automatic cyc1(input bit de, input int x, input int y,
                       input bit fs, input bit clr);
      display_enable = de;
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      frame_sync = fs;
      clear_status = clr;
      tick();
   endtask

   task automatic blank(input int n, input int y);
      repeat (n) cyc1(0, int'($urandom_range(639)), y, 0, 0);
   endtask

   task automatic line(input int y, input int n, input bit full);
      for (int k = 0; k < n; k++)
         cyc1(1, full ? k : int'($urandom_range(639)), y, 0, 0);
   endtask

   task automatic fsync(input int base);
      fb_base = 15'(base);
      cyc1(0, 0, 0, 1, 0);
   endtask

   task automatic frame(input int nlines, input int base, input bit full0);
      fsync(base);
      blank(170, 0);
      for (int y = 0; y < nlines; y++) begin
         line(y, (full0 && y == 0) ? 640 : 40, full0 && y == 0);
         blank(12, y);
      end
   endtask

   initial begin
      model_reset();
      @(posedge pixel_clk);
      #1;
      running = 1;
      reset = 1'b1;
      repeat (3) cyc1(0, 0, 0, 0, 0);
      reset = 1'b0;
      blank(4, 0);

      frame(480, 0, 1);
      blank(20, 479);

      frame(8, 15'h7F00, 0);
      blank(20, 7);

      fsync(0);
      blank(60, 0);
      fsync(15'h1234);
      blank(60, 0);
      fsync(15'h0A00);
      blank(5, 4);
      line(4, 20, 0);
      blank(5, 4);
      cyc1(0, 0, 4, 0, 1);
      blank(200, 4);
      cyc1(0, 0, 4, 0, 1);
      blank(3, 4);

      fsync(15'h0100);
      blank(30, 0);
      line(0, 3, 0);
      blank(200, 0);
      cyc1(0, 0, 0, 0, 1);
      blank(3, 0);

      fsync(15'h0200);
      blank(50, 0);
      reset = 1'b1;
      cyc1(0, 0, 0, 0, 0);
      cyc1(0, 0, 0, 0, 0);
      reset = 1'b0;
      blank(5, 0);
      frame(8, 15'h0300, 0);
      blank(20, 7);

      running = 0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
